// File: rtl/btn_cond_pkg.sv
// Shared keypad constants for the button front end and the lock state machine.
package btn_cond_pkg;

    localparam int unsigned NUM_BTNS = 4;

    typedef logic [1:0] key_code_t;

    localparam key_code_t KEY_A = 2'd0;
    localparam key_code_t KEY_B = 2'd1;
    localparam key_code_t KEY_C = 2'd2;
    localparam key_code_t KEY_D = 2'd3;

    // Index of the lowest set bit; A (bit 0) wins over every other button.
    function automatic key_code_t lowest_set(input logic [NUM_BTNS-1:0] v);
        lowest_set = KEY_A;
        for (int unsigned i = NUM_BTNS; i > 0; i--) begin
            if (v[i-1]) begin
                lowest_set = key_code_t'(i - 1);
            end
        end
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, level/press registers.
// Define BTN_COND_AUTOREPEAT_EN to add the hold-to-repeat counter.
module button_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_debounce_channel: invalid timing parameters");
    end

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == CNT_MAX);

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          rep_initial;
    logic [RW-1:0] rep_limit;

    // First repeat waits REPEAT_DELAY, subsequent ones REPEAT_PERIOD.
    assign rep_limit = rep_initial ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
            rcnt        <= '0;
            rep_initial <= 1'b1;
`endif
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;

            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

`ifdef BTN_COND_AUTOREPEAT_EN
            // Any level change (press or release) restarts the repeat timing.
            if (!level || accept) begin
                rcnt        <= '0;
                rep_initial <= 1'b1;
            end else if (rcnt == rep_limit) begin
                press       <= 1'b1;
                rcnt        <= '0;
                rep_initial <= 1'b0;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Keypad front end: four debounced buttons plus a registered priority key event.
// Auto-repeat is compiled in only when BTN_COND_AUTOREPEAT_EN is defined.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic                key_valid,
    output logic [1:0]          key_code,
    output logic                key_multi
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    // Lower-priority coincident presses are folded into key_multi only.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= KEY_A;
            key_multi <= 1'b0;
        end else if (|btn_press) begin
            key_valid <= 1'b1;
            key_code  <= lowest_set(btn_press);
            key_multi <= ($countones(btn_press) > 1);
        end else begin
            key_valid <= 1'b0;
            key_multi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a timing-rule reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_multi;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_multi(key_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a button level flips once the synchronized input has
    // disagreed with it for D consecutive edges (tracked as time since last agreement).
    int         cyc = 0;
    bit   [3:0] m_s1, m_s2, m_lvl, m_press;
    int         last_match [4];
    int         press_t    [4];
    bit         m_kv, m_km;
    bit   [1:0] m_kc;

    always @(posedge clk) begin : model
        bit [3:0] prev_press;
        bit       flipped;
        int       age;
        prev_press = m_press;
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
            m_kv = 0; m_kc = 0; m_km = 0;
            for (int b = 0; b < 4; b++) begin
                last_match[b] = cyc;
                press_t[b]    = cyc;
            end
        end else begin
            m_kv = (prev_press != 0);
            m_km = ($countones(prev_press) > 1);
            if (m_kv) begin
                for (int b = 3; b >= 0; b--) if (prev_press[b]) m_kc = 2'(b);
            end
            for (int b = 0; b < 4; b++) begin
                flipped    = 0;
                m_press[b] = 0;
                if (m_s2[b] == m_lvl[b]) begin
                    last_match[b] = cyc;
                end else if (cyc - last_match[b] >= D) begin
                    m_lvl[b]      = m_s2[b];
                    m_press[b]    = m_lvl[b];
                    last_match[b] = cyc;
                    flipped       = 1;
                    if (m_lvl[b]) press_t[b] = cyc;
                end
`ifdef BTN_COND_AUTOREPEAT_EN
                if (!flipped && m_lvl[b]) begin
                    age = cyc - press_t[b];
                    if (age == RD || (age > RD && (age - RD) % RP == 0)) m_press[b] = 1;
                end
`else
                age = flipped ? 1 : 0;
`endif
                m_s2[b] = m_s1[b];
                m_s1[b] = btn_raw[b];
            end
        end
    end

    always @(negedge clk) begin : compare
        if (cyc > 0) begin
            chk("btn_level", btn_level, m_lvl);
            chk("btn_press", btn_press, m_press);
            chk("key_valid", key_valid, m_kv);
            chk("key_code",  key_code,  m_kc);
            chk("key_multi", key_multi, m_km);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n_press;
    int n_key;

    initial begin
        rst = 1'b1;
        btn_raw = 4'hF;
        step(3);
        chk("rst_level", btn_level, 4'h0);
        chk("rst_press", btn_press, 4'h0);
        chk("rst_key",   {key_valid, key_code, key_multi}, 4'h0);
        rst = 1'b0;
        step(6);
        chk("rel_press", btn_press, 4'hF);
        chk("rel_level", btn_level, 4'hF);
        step(1);
        chk("rel_key", {key_valid, key_code, key_multi}, {1'b1, 2'd0, 1'b1});
        btn_raw = 4'h0;
        step(12);

        // Clean press of B, then release after 10 cycles.
        btn_raw = 4'h2;
        step(5);
        chk("b_early", btn_press, 4'h0);
        step(1);
        chk("b_press", btn_press, 4'h2);
        step(1);
        chk("b_key", {key_valid, key_code}, {1'b1, 2'd1});
        step(3);
        btn_raw = 4'h0;
        step(5);
        chk("b_hold", btn_level, 4'h2);
        step(1);
        chk("b_rel_level", btn_level, 4'h0);
        chk("b_rel_press", btn_press, 4'h0);
        step(6);

        // Bouncing C: short glitches, then a stable high.
        n_press = 0;
        n_key   = 0;
        for (int t = 0; t < 10; t++) begin
            btn_raw[2] = ~btn_raw[2];
            for (int k = 0; k < 2; k++) begin
                step(1);
                n_press += btn_press[2];
                n_key   += key_valid;
            end
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 6) chk("c_press_edge", btn_press[2], 1'b1);
            n_press += btn_press[2];
            n_key   += key_valid;
        end
        chk("c_press_count", n_press, 1);
        chk("c_key_count", n_key, 1);
        chk("c_code", key_code, 2'd2);
        btn_raw = 4'h0;
        step(12);

        // C and D together: one event for C, flagged multi.
        btn_raw = 4'hC;
        step(6);
        chk("cd_press", btn_press, 4'hC);
        step(1);
        chk("cd_key", {key_valid, key_code, key_multi}, {1'b1, 2'd2, 1'b1});
        step(1);
        chk("cd_no_d", key_valid, 1'b0);
        btn_raw = 4'h0;
        step(12);

        // Reset in the middle of qualifying A.
        btn_raw = 4'h1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        chk("a_rst_nopulse", btn_press, 4'h0);
        step(4);
        chk("a_rst_press", btn_press, 4'h1);
        btn_raw = 4'h0;
        step(12);

        // A held: one pulse, or a repeat train when auto-repeat is built in.
        n_press = 0;
        btn_raw = 4'h1;
        for (int k = 1; k <= 55; k++) begin
            step(1);
            n_press += btn_press[0];
`ifdef BTN_COND_AUTOREPEAT_EN
            if (k == 26) chk("a_rep_first", btn_press[0], 1'b1);
`else
            if (k == 26) chk("a_no_rep", btn_press[0], 1'b0);
`endif
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_press += btn_press[0];
        end
`ifdef BTN_COND_AUTOREPEAT_EN
        chk("a_rep_count", n_press, 6);
`else
        chk("a_single", n_press, 1);
`endif
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the lock's four keypad buttons A–D. Each raw, asynchronous button line is synchronized, debounced with a per-button counter, and converted into a clean level plus a single-cycle press pulse. A priority encoder also produces a registered key event (valid + 2-bit code) that the lock state machine consumes directly as "one key pressed" per event.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required before a level change is accepted; ≥2.
- REPEAT_DELAY, 50_000_000: cycles from press pulse to first repeat pulse; used only when `BTN_COND_AUTOREPEAT_EN` is defined.
- REPEAT_PERIOD, 10_000_000: cycles between later repeat pulses; used only when `BTN_COND_AUTOREPEAT_EN` is defined.
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- btn_raw  in  4  raw buttons; bit0=A, bit1=B, bit2=C, bit3=D; asynchronous, high = pressed.
- btn_level  out  4  debounced level per button.
- btn_press  out  4  one-cycle pulse per button on an accepted press.
- key_valid  out  1  one-cycle key event.
- key_code  out  2  event code: 0=A, 1=B, 2=C, 3=D; held between events.
- key_multi  out  1  pulses with key_valid when more than one press pulse occurred in the same cycle.

## Operation
- Synchronizer: 2 flops per bit (sync1, sync2).
- Debounce (per bit), with counter cnt of width clog2(DEBOUNCE_CYCLES):
  - sync2 == btn_level: cnt ← 0.
  - Mismatch and cnt < DEBOUNCE_CYCLES−1: cnt ← cnt+1.
  - Mismatch and cnt == DEBOUNCE_CYCLES−1: btn_level ← sync2 and cnt ← 0.
  - btn_press is registered high in the same cycle btn_level goes 0→1. A 1→0 transition produces no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES samples clears cnt and is never accepted.
- Encoder: registered from the btn_press vector.
  - Any bit set: key_valid ← 1; key_code ← lowest set index (A has highest priority); key_multi ← (popcount > 1).
  - Otherwise key_valid ← 0, key_multi ← 0, and key_code holds its value.
  - Lower-priority presses that coincide with a higher-priority press are dropped as key events. They still appear on btn_press.
- Reset values: sync flops 0, cnt 0, btn_level 0, btn_press 0, key_valid 0, key_code 0, key_multi 0, repeat counters 0.
- Reset asserted mid-count discards the partial count. A button held through reset release must be re-qualified from zero and produces a fresh press pulse after the full latency.

## Timing
- Edge E0 is the first clk edge that samples a new raw level.
- btn_level and btn_press change after edge E0+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after the raw change.
- key_valid follows btn_press by exactly 1 cycle.
- btn_press and key_valid are each high for exactly 1 cycle per event. Events can occur on consecutive cycles when different buttons qualify on consecutive cycles.
- There is no back-pressure. The consumer must accept key_valid in the cycle it is high.

## Configuration
- `BTN_COND_AUTOREPEAT_EN` defined:
  - While btn_level stays high, a per-button repeat counter issues an extra btn_press REPEAT_DELAY cycles after the initial press pulse, then one every REPEAT_PERIOD cycles.
  - Release, or rst, clears the repeat counter immediately.
  - Repeat pulses flow through the encoder like normal presses.
- Undefined: exactly one btn_press per accepted press. No repeat logic is instantiated and REPEAT_* are ignored. This is the default build for the lock, which must see one event per press.

## Structure
- Shared package btn_cond_pkg holds:
  - key code constants KEY_A=2'd0, KEY_B=2'd1, KEY_C=2'd2, KEY_D=2'd3;
  - NUM_BTNS=4.
  The lock state machine imports the same constants.
- Sub-module button_debounce_channel contains one button's synchronizer, counter, level/press registers and optional repeat counter. It is instantiated 4× with a generate loop.
- The priority encoder stays in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: hold rst 3 cycles with btn_raw=4'hF → all outputs 0. After release, btn_level=4'hF and btn_press=4'hF after 6 edges, then key_valid=1, key_code=0, key_multi=1.
- Clean press: B held high → btn_press[1] pulses once at edge E0+5 and key_valid/key_code=1 at E0+6. Releasing after 10 cycles → btn_level[1] falls 6 edges later with no pulse.
- Bounce: C toggles every 2 cycles for 20 cycles then stays high → exactly one btn_press[2] and one key event (code 2), 6 edges after the final toggle.
- Simultaneous: C and D rise on the same cycle → btn_press=4'b1100, then key_code=2, key_multi=1, and no separate D event.
- Reset mid-debounce: A rises, rst pulses at E0+3 → no pulse at E0+5. A still held → press pulse 6 edges after rst deasserts.
- `BTN_COND_AUTOREPEAT_EN`: A held 60 cycles → press pulses at t, t+20, t+28, t+36, t+44, t+52. Without the macro → a single pulse.
